// File: rtl/seq_detect_ctrl.sv
// Word-level controller for the serial pattern detector: accepts a word, shifts it
// MSB-first through a programmable Moore matcher, and reports per-bit detects and a match count.
module seq_detect_ctrl #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned MAX_PAT = 8,
    parameter int unsigned CNT_W   = $clog2(DATA_W + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [MAX_PAT-1:0] cfg_pattern,
    input  logic [3:0]         cfg_len,
    input  logic               cfg_overlap,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    output logic               det,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   match_count
);

    localparam int unsigned LEN_W = $clog2(MAX_PAT + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]         state_q,  state_d;
    logic [DATA_W-1:0]  data_q,   data_d;
    logic [MAX_PAT-1:0] pat_q,    pat_d;
    logic [LEN_W-1:0]   len_q,    len_d;
    logic               ovl_q,    ovl_d;
    logic [MAX_PAT-2:0] hist_q,   hist_d;
    logic [LEN_W-1:0]   fill_q,   fill_d;
    logic [CNT_W-1:0]   bitcnt_q, bitcnt_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic               det_q,    det_d;

    logic [LEN_W-1:0]   len_clamped;
    logic [MAX_PAT-1:0] new_hist;
    logic [MAX_PAT-1:0] mask;
    logic               fill_ok;
    logic               match;

    always_comb begin
        if (cfg_len == 4'd0) begin
            len_clamped = LEN_W'(1);
        end else if (32'(cfg_len) > MAX_PAT) begin
            len_clamped = LEN_W'(MAX_PAT);
        end else begin
            len_clamped = LEN_W'(cfg_len);
        end
    end

    // Only the top MAX_PAT-1 history bits are stored; the incoming bit completes the window.
    always_comb begin
        new_hist = {hist_q, data_q[DATA_W-1]};
        mask     = '0;
        for (int unsigned i = 0; i < MAX_PAT; i++) begin
            mask[i] = (i < 32'(len_q));
        end
        fill_ok = (32'(fill_q) + 32'd1) >= 32'(len_q);
        match   = fill_ok && (((new_hist ^ pat_q) & mask) == '0);
    end

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        pat_d    = pat_q;
        len_d    = len_q;
        ovl_d    = ovl_q;
        hist_d   = hist_q;
        fill_d   = fill_q;
        bitcnt_d = bitcnt_q;
        cnt_d    = cnt_q;
        det_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d   = in_data;
                    pat_d    = cfg_pattern;
                    len_d    = len_clamped;
                    ovl_d    = cfg_overlap;
                    hist_d   = '0;
                    fill_d   = '0;
                    bitcnt_d = '0;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                data_d   = data_q << 1;
                hist_d   = new_hist[MAX_PAT-2:0];
                det_d    = match;
                bitcnt_d = bitcnt_q + CNT_W'(1);
                if (match) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // Non-overlapping mode forces a full fresh window before the next match.
                if (match && !ovl_q) begin
                    fill_d = '0;
                end else if (fill_ok) begin
                    fill_d = len_q;
                end else begin
                    fill_d = fill_q + LEN_W'(1);
                end
                if (bitcnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            data_q   <= '0;
            pat_q    <= '0;
            len_q    <= '0;
            ovl_q    <= 1'b0;
            hist_q   <= '0;
            fill_q   <= '0;
            bitcnt_q <= '0;
            cnt_q    <= '0;
            det_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            pat_q    <= pat_d;
            len_q    <= len_d;
            ovl_q    <= ovl_d;
            hist_q   <= hist_d;
            fill_q   <= fill_d;
            bitcnt_q <= bitcnt_d;
            cnt_q    <= cnt_d;
            det_q    <= det_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign busy        = (state_q == SHIFT) || (state_q == DONE);
    assign done        = (state_q == DONE);
    assign det         = det_q;
    assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl: hand-computed detect positions and counts per word.
module tb_seq_detect_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  cfg_pattern;
    logic [3:0]  cfg_len;
    logic        cfg_overlap;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        det;
    logic        busy;
    logic        done;
    logic [4:0]  match_count;

    int checks = 0;
    int errors = 0;

    seq_detect_ctrl #(.DATA_W(16), .MAX_PAT(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .det         (det),
        .busy        (busy),
        .done        (done),
        .match_count (match_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setup(input logic [7:0] pat, input logic [3:0] len,
                         input logic ovl, input logic [15:0] data);
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        in_data     = data;
    endtask

    // Called right after the accept edge; returns with the DUT in DONE.
    task automatic scan(input string tag, input logic [15:0] exp_det, input logic [4:0] exp_cnt);
        logic [15:0] got_det;
        logic [15:0] got_done;
        logic        rdy_seen;
        chk({tag, "_det_first"}, 32'(det), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        got_det  = '0;
        got_done = '0;
        rdy_seen = in_ready;
        for (int i = 0; i < 16; i++) begin
            tick();
            got_det[i]  = det;
            got_done[i] = done;
            rdy_seen    = rdy_seen | in_ready;
        end
        chk({tag, "_det_vec"}, 32'(got_det), 32'(exp_det));
        chk({tag, "_done_pos"}, 32'(got_done), 32'h8000);
        chk({tag, "_ready_busy"}, 32'(rdy_seen), 32'd0);
        chk({tag, "_count"}, 32'(match_count), 32'(exp_cnt));
    endtask

    task automatic finish_word(input string tag, input logic [4:0] exp_cnt);
        tick();
        chk({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_idle_done"}, 32'(done), 32'd0);
        chk({tag, "_idle_det"}, 32'(det), 32'd0);
        chk({tag, "_hold_count"}, 32'(match_count), 32'(exp_cnt));
    endtask

    task automatic run_word(input string tag, input logic [7:0] pat, input logic [3:0] len,
                            input logic ovl, input logic [15:0] data,
                            input logic [15:0] exp_det, input logic [4:0] exp_cnt);
        setup(pat, len, ovl, data);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        scan(tag, exp_det, exp_cnt);
        finish_word(tag, exp_cnt);
    endtask

    initial begin
        logic done_seen;
        reset    = 1'b1;
        in_valid = 1'b0;
        setup(8'h00, 4'd1, 1'b0, 16'h0000);
        tick();
        tick();
        reset = 1'b0;
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_det", 32'(det), 32'd0);
        chk("rst_count", 32'(match_count), 32'd0);
        tick();
        chk("idle_ready", 32'(in_ready), 32'd1);

        run_word("p001", 8'h01, 4'd3, 1'b0, 16'h2492, 16'h4924, 5'd5);
        run_word("p11_ovl", 8'h03, 4'd2, 1'b1, 16'hF000, 16'h000E, 5'd3);
        run_word("p11_novl", 8'h03, 4'd2, 1'b0, 16'hF000, 16'h000A, 5'd2);
        run_word("len1", 8'h01, 4'd1, 1'b0, 16'hFFFF, 16'hFFFF, 5'd16);
        run_word("len0", 8'hFF, 4'd0, 1'b0, 16'hFFFF, 16'hFFFF, 5'd16);
        run_word("len_clamp", 8'hA5, 4'd15, 1'b0, 16'hA5A5, 16'h8080, 5'd2);

        // Reset in the 8th SHIFT cycle aborts the word without a done pulse.
        setup(8'h01, 4'd1, 1'b0, 16'hFFFF);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("mid_count_pre", 32'(match_count), 32'd7);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_ready", 32'(in_ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_det", 32'(det), 32'd0);
        chk("abort_count", 32'(match_count), 32'd0);
        done_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            done_seen = done_seen | done | busy;
        end
        chk("abort_no_done", 32'(done_seen), 32'd0);
        run_word("after_abort", 8'h01, 4'd3, 1'b0, 16'h2492, 16'h4924, 5'd5);

        // Back-to-back with in_valid held; config changes mid-word must not matter.
        setup(8'h01, 4'd3, 1'b0, 16'h2492);
        in_valid = 1'b1;
        tick();
        setup(8'h03, 4'd2, 1'b0, 16'hF000);
        scan("b2b_first", 16'h4924, 5'd5);
        tick();
        chk("b2b_idle_ready", 32'(in_ready), 32'd1);
        chk("b2b_idle_busy", 32'(busy), 32'd0);
        chk("b2b_idle_count", 32'(match_count), 32'd5);
        tick();
        chk("b2b_second_accept", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        scan("b2b_second", 16'h000A, 5'd2);
        finish_word("b2b_second", 5'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
